alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter EXEC_CYCLES, default 1, number of cycles alu_enable is held high per operation (legal range 1..15).
REQ-002 The block SHALL have the following ports, one clock and one asynchronous active-low reset:
  clk  input  1  sole clock, all state updates on rising edge
  reset_n  input  1  asynchronous active-low reset
  req  input  2  per-requester operation request, bit i = requester i
  op_a0, op_b0  input  16 each  requester 0 operands
  sel0  input  3  requester 0 ALU operation select
  cin0  input  1  requester 0 carry in
  op_a1, op_b1  input  16 each  requester 1 operands
  sel1  input  3  requester 1 ALU operation select
  cin1  input  1  requester 1 carry in
  gnt  output  2  one-hot grant, bit i = requester i owns the ALU
  done  output  2  one-cycle completion pulse to the owning requester
  result  output  16  registered ALU result of the last completed operation
  carry  output  1  registered carry out of the last completed operation
  zero  output  1  registered zero flag of the last completed operation
  alu_in_1, alu_in_2  output  16 each  operands driven to the ALU
  alu_select  output  3  operation select driven to the ALU
  alu_carry_in  output  1  carry in driven to the ALU
  alu_enable  output  1  ALU enable / bus access
  alu_data  input  16  ALU result bus
  alu_carry_out  input  1  ALU carry out
  alu_zero  input  1  ALU zero flag

Function
REQ-003 The block SHALL implement FSM states IDLE, LOAD, EXEC, DONE.
REQ-004 IDLE: if any req bit is high at a rising edge, the block SHALL select a winner, assert its gnt bit and enter LOAD; otherwise remain IDLE with gnt=00.
REQ-005 Arbitration SHALL be round-robin: a single request wins outright; with req=11 the requester not granted most recently wins; the last-granted pointer resets to requester 1, so requester 0 wins the first contention.
REQ-006 On the grant edge the winner's op_a, op_b, sel, cin SHALL be latched into internal registers; alu_in_1, alu_in_2, alu_select, alu_carry_in SHALL be driven from these registers and SHALL NOT change until the next grant.
REQ-007 LOAD SHALL last exactly one cycle with alu_enable=0 so operands are stable before the enable rising edge; next state EXEC.
REQ-008 EXEC SHALL hold alu_enable=1 for exactly EXEC_CYCLES cycles, counted by an internal counter cleared on entry to EXEC.
REQ-009 At the rising edge ending the last EXEC cycle the block SHALL register alu_data into result, alu_carry_out into carry, alu_zero into zero, drop alu_enable, and enter DONE.
REQ-010 DONE SHALL last one cycle with the owner's done bit high and gnt still asserted; next edge SHALL return to IDLE with gnt=00 and done=00.
REQ-011 Latency: req sampled at edge N in IDLE -> gnt from N+1, alu_enable high from N+2 through N+1+EXEC_CYCLES, result valid and done high from N+2+EXEC_CYCLES, gnt low from N+3+EXEC_CYCLES.
REQ-012 Back-to-back: a request pending in the DONE cycle SHALL be granted at the edge after IDLE is entered; minimum spacing between grants is EXEC_CYCLES+3 cycles.
REQ-013 gnt SHALL be one-hot or zero; done SHALL never be high for the non-owner and never two consecutive cycles.
REQ-014 Deassertion of the owner's req after grant SHALL NOT abort the operation; it SHALL complete and pulse done.
REQ-015 Changes on op_a/op_b/sel/cin after the grant edge SHALL NOT affect the in-flight operation.
REQ-016 result, carry, zero SHALL hold their values between completions.
REQ-017 All 8 sel encodings SHALL be passed to the ALU unmodified; the block SHALL not interpret them.

Reset
REQ-018 reset_n low SHALL immediately, without a clock, force state IDLE, gnt=00, done=00, alu_enable=0, result=0, carry=0, zero=0, operand/select/cin registers=0, exec counter=0, last-granted pointer=1.
REQ-019 Reset asserted mid-operation SHALL abort it with no done pulse and no result update; operation resumes only via a new request after reset_n returns high.

Verification
REQ-020 Single: req=01, op_a0=0x0003, op_b0=0x0004, sel0=0, cin0=1, EXEC_CYCLES=1 -> gnt=01 at N+1, alu_enable high one cycle at N+2, done=01 at N+3 with result=0x0008, carry=0, zero=0.
REQ-021 Contention: req=11 held continuously from reset -> grants 01,10,01,10 in order, each done on the matching bit, spacing 4 cycles.
REQ-022 Flags: requester 1 sel1=0, op_a1=0xFFFF, op_b1=0x0001, cin1=0 -> result=0x0000, carry=1, zero=1 with done=10.
REQ-023 Req drop and operand change: requester 0 drops req and changes op_a0 one cycle after grant -> operation completes with originally latched operands, done=01.
REQ-024 Reset mid-EXEC with EXEC_CYCLES=3: reset_n low during second EXEC cycle -> alu_enable=0, gnt=00 immediately, no done, result unchanged at 0.
REQ-025 EXEC_CYCLES=4: alu_enable high exactly 4 cycles, done 6 cycles after request sampling.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter that owns an external ALU: latches the winner's
// operands, holds alu_enable for EXEC_CYCLES cycles, registers the ALU result and pulses done.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [15:0] op_a0,
  input  logic [15:0] op_b0,
  input  logic [2:0]  sel0,
  input  logic        cin0,
  input  logic [15:0] op_a1,
  input  logic [15:0] op_b1,
  input  logic [2:0]  sel1,
  input  logic        cin1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero,
  output logic [15:0] alu_in_1,
  output logic [15:0] alu_in_2,
  output logic [2:0]  alu_select,
  output logic        alu_carry_in,
  output logic        alu_enable,
  input  logic [15:0] alu_data,
  input  logic        alu_carry_out,
  input  logic        alu_zero,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a requester holds req until it sees its gnt bit; from then on the operation
  // is committed (req may drop) and ends with exactly one done pulse while gnt is still high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [2:0]  sel_q, sel_d;
  logic        cin_q, cin_d;
  logic [15:0] res_q, res_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        win;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      sel_q   <= 3'd0;
      cin_q   <= 1'b0;
      res_q   <= 16'd0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    cin_d   = cin_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    // On contention the requester that was not granted last wins.
    win     = (req == 2'b11) ? ~last_q : req[1];
    case (state_q)
      IDLE: begin
        gnt_d = 2'b00;
        if (|req) begin
          state_d = LOAD;
          gnt_d   = win ? 2'b10 : 2'b01;
          last_d  = win;
          a_d     = win ? op_a1 : op_a0;
          b_d     = win ? op_b1 : op_b0;
          sel_d   = win ? sel1  : sel0;
          cin_d   = win ? cin1  : cin0;
        end
      end
      LOAD: begin
        state_d = EXEC;
        cnt_d   = 4'd0;
      end
      EXEC: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          res_d   = alu_data;
          carry_d = alu_carry_out;
          zero_d  = alu_zero;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  assign gnt          = gnt_q;
  assign done         = (state_q == DONE) ? gnt_q : 2'b00;
  assign alu_enable   = (state_q == EXEC);
  assign result       = res_q;
  assign carry        = carry_q;
  assign zero         = zero_q;
  assign alu_in_1     = a_q;
  assign alu_in_2     = b_q;
  assign alu_select   = sel_q;
  assign alu_carry_in = cin_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: three instances (EXEC_CYCLES 1, 3, 4) each driving a behavioural ALU;
// instance 0 results are checked through an expected queue.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n;
  logic [1:0]  req;
  logic [15:0] op_a0, op_b0, op_a1, op_b1;
  logic [2:0]  sel0, sel1;
  logic        cin0, cin1;

  logic [1:0]  gnt [3];
  logic [1:0]  done [3];
  logic [15:0] result [3];
  logic        carry [3];
  logic        zero [3];
  logic [15:0] alu_in_1 [3];
  logic [15:0] alu_in_2 [3];
  logic [2:0]  alu_select [3];
  logic        alu_carry_in [3];
  logic        alu_enable [3];
  logic [1:0]  dbg [3];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  logic [19:0] exp_q[$];
  logic [1:0]  prev_done0 = 2'b00;

  // Behavioural ALU: {carry_out, data}
  function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] s, input logic c);
    logic [16:0] r;
    case (s)
      3'd0: r = {1'b0, a} + {1'b0, b} + {16'd0, c};
      3'd1: r = {1'b0, a} - {1'b0, b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {a, 1'b0};
      default: r = {a[0], 1'b0, a[15:1]};
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned EC = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [16:0] alu_r;
    logic [15:0] alu_data;
    logic        alu_cout;
    logic        alu_z;
    assign alu_r    = alu_f(alu_in_1[g], alu_in_2[g], alu_select[g], alu_carry_in[g]);
    assign alu_data = alu_r[15:0];
    assign alu_cout = alu_r[16];
    assign alu_z    = (alu_r[15:0] == 16'd0);

    alu_arbiter #(.EXEC_CYCLES(EC)) u_dut (
      .clk(clk), .reset_n(rst_n[g]), .req(req),
      .op_a0(op_a0), .op_b0(op_b0), .sel0(sel0), .cin0(cin0),
      .op_a1(op_a1), .op_b1(op_b1), .sel1(sel1), .cin1(cin1),
      .gnt(gnt[g]), .done(done[g]), .result(result[g]), .carry(carry[g]), .zero(zero[g]),
      .alu_in_1(alu_in_1[g]), .alu_in_2(alu_in_2[g]), .alu_select(alu_select[g]),
      .alu_carry_in(alu_carry_in[g]), .alu_enable(alu_enable[g]),
      .alu_data(alu_data), .alu_carry_out(alu_cout), .alu_zero(alu_z),
      .dbg_state_o(dbg[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_ops(input bit r, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] s, input logic c);
    if (r) begin
      op_a1 = a; op_b1 = b; sel1 = s; cin1 = c;
    end else begin
      op_a0 = a; op_b0 = b; sel0 = s; cin0 = c;
    end
  endtask

  task automatic push_exp(input bit r, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] s, input logic c);
    logic [16:0] m;
    m = alu_f(a, b, s, c);
    exp_q.push_back({(r ? 2'b10 : 2'b01), m[16], (m[15:0] == 16'd0), m[15:0]});
  endtask

  // One full operation on instance 0 (EXEC_CYCLES=1), starting and ending in IDLE.
  task automatic run_op(input bit r, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] s, input logic c);
    logic [1:0] g1h;
    g1h = r ? 2'b10 : 2'b01;
    set_ops(r, a, b, s, c);
    push_exp(r, a, b, s, c);
    req = g1h;
    tick();
    chk("grant", gnt[0], g1h);
    chk("load_en", alu_enable[0], 0);
    req = 2'b00;
    tick();
    chk("exec_en", alu_enable[0], 1);
    chk("alu_sel", alu_select[0], s);
    chk("alu_in1", alu_in_1[0], a);
    chk("alu_in2", alu_in_2[0], b);
    chk("alu_cin", alu_carry_in[0], c);
    tick();
    chk("done", done[0], g1h);
    chk("done_gnt", gnt[0], g1h);
    chk("done_en", alu_enable[0], 0);
    tick();
    chk("gnt_rel", gnt[0], 0);
    chk("done_rel", done[0], 0);
  endtask

  // Scoreboard monitor for instance 0
  always @(negedge clk) begin
    logic [19:0] e;
    chk("gnt_1hot", {31'd0, $onehot0(gnt[0])}, 1);
    if (done[0] != 2'b00) begin
      chk("done_twice", prev_done0, 0);
      chk("done_owner", done[0] & ~gnt[0], 0);
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL sb_unexpected got=%0h exp=none", {done[0], carry[0], zero[0], result[0]});
      end else begin
        e = exp_q.pop_front();
        chk("sb", {done[0], carry[0], zero[0], result[0]}, e);
      end
    end
    prev_done0 = done[0];
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tmo;
    int last_g;
    int en_cnt;
    int done_at;
    logic [1:0] exp_g;
    rst_n = 3'b000;
    req   = 2'b00;
    op_a0 = 0; op_b0 = 0; sel0 = 0; cin0 = 0;
    op_a1 = 0; op_b1 = 0; sel1 = 0; cin1 = 0;
    tick();
    tick();
    for (int g = 0; g < 3; g++) begin
      chk("rst_gnt", gnt[g], 0);
      chk("rst_done", done[g], 0);
      chk("rst_en", alu_enable[g], 0);
      chk("rst_res", result[g], 0);
      chk("rst_flags", {carry[g], zero[g]}, 0);
      chk("rst_ops", {alu_in_1[g], alu_in_2[g]}, 0);
      chk("rst_selcin", {alu_select[g], alu_carry_in[g]}, 0);
      chk("rst_state", dbg[g], 0);
    end
    rst_n[0] = 1'b1;
    tick();

    // Single add with carry in
    run_op(1'b0, 16'h0003, 16'h0004, 3'd0, 1'b1);
    chk("single_res", result[0], 16'h0008);
    chk("single_flags", {carry[0], zero[0]}, 0);

    // Carry and zero flags from requester 1
    run_op(1'b1, 16'hFFFF, 16'h0001, 3'd0, 1'b0);
    chk("flags_res", result[0], 16'h0000);
    chk("flags_cz", {carry[0], zero[0]}, 2'b11);

    // Result holds between completions
    repeat (3) tick();
    chk("hold_res", result[0], 16'h0000);
    chk("hold_cz", {carry[0], zero[0]}, 2'b11);

    // All select encodings, random operands and requester
    for (int s = 0; s < 8; s++) begin
      run_op(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
             16'($urandom_range(0, 65535)), 3'(s), 1'($urandom_range(0, 1)));
    end

    // Owner drops req and changes operands after grant
    set_ops(1'b0, 16'h0100, 16'h0022, 3'd1, 1'b0);
    push_exp(1'b0, 16'h0100, 16'h0022, 3'd1, 1'b0);
    req = 2'b01;
    tick();
    chk("drop_gnt", gnt[0], 2'b01);
    req = 2'b00;
    set_ops(1'b0, 16'hAAAA, 16'h5555, 3'd7, 1'b1);
    tick();
    chk("drop_in1", alu_in_1[0], 16'h0100);
    chk("drop_sel", alu_select[0], 3'd1);
    tick();
    chk("drop_done", done[0], 2'b01);
    chk("drop_res", result[0], 16'h00DE);
    tick();
    chk("drop_idle", gnt[0], 0);

    // Contention from reset: alternating grants, 4 cycles apart
    rst_n[0] = 1'b0;
    set_ops(1'b0, 16'h1234, 16'h1111, 3'd0, 1'b0);
    set_ops(1'b1, 16'h0F0F, 16'h00FF, 3'd4, 1'b0);
    req = 2'b11;
    tick();
    rst_n[0] = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(k[0], k[0] ? 16'h0F0F : 16'h1234,
                                         k[0] ? 16'h00FF : 16'h1111, k[0] ? 3'd4 : 3'd0, 1'b0);
    last_g = 0;
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0] ? 2'b10 : 2'b01;
      tmo = 0;
      while (gnt[0] == 2'b00 && tmo < 10) begin
        tick();
        tmo++;
      end
      chk("cont_gnt", gnt[0], exp_g);
      if (k > 0) chk("cont_space", cyc - last_g, 4);
      last_g = cyc;
      if (k == 3) req = 2'b00;
      tmo = 0;
      while (gnt[0] != 2'b00 && tmo < 10) begin
        tick();
        tmo++;
      end
      chk("cont_rel_tmo", (tmo < 10), 1);
    end
    tick();
    tick();
    chk("sb_empty", exp_q.size(), 0);
    rst_n[0] = 1'b0;

    // EXEC_CYCLES=3: reset in the second EXEC cycle aborts the operation
    rst_n[1] = 1'b1;
    tick();
    set_ops(1'b0, 16'h0003, 16'h0004, 3'd0, 1'b1);
    req = 2'b01;
    tick();
    chk("e3_gnt", gnt[1], 2'b01);
    req = 2'b00;
    tick();
    chk("e3_en1", alu_enable[1], 1);
    tick();
    chk("e3_en2", alu_enable[1], 1);
    #2;
    rst_n[1] = 1'b0;
    #1;
    chk("e3_rst_en", alu_enable[1], 0);
    chk("e3_rst_gnt", gnt[1], 0);
    chk("e3_rst_done", done[1], 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("e3_no_done", done[1], 0);
      chk("e3_res0", result[1], 0);
    end
    rst_n[1] = 1'b1;
    repeat (3) tick();
    chk("e3_idle", dbg[1], 0);
    chk("e3_idle_gnt", gnt[1], 0);
    rst_n[1] = 1'b0;

    // EXEC_CYCLES=4: enable exactly 4 cycles, done 5 edges after the grant edge
    rst_n[2] = 1'b1;
    tick();
    set_ops(1'b1, 16'h00F0, 16'h0F00, 3'd3, 1'b0);
    req = 2'b10;
    tick();
    chk("e4_gnt", gnt[2], 2'b10);
    req = 2'b00;
    en_cnt  = 0;
    done_at = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (alu_enable[2]) en_cnt++;
      if (done[2] != 2'b00 && done_at < 0) begin
        done_at = i;
        chk("e4_done", done[2], 2'b10);
        chk("e4_res", result[2], 16'h0FF0);
      end
    end
    chk("e4_en_cnt", en_cnt, 4);
    chk("e4_done_at", done_at, 5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
